cic_interp_scheduler: RTL and testbench

- Sequencing controller for the 4-stage CIC interpolator in the SDR transmit chain.
- Generates the interpolator's input/output strobes from a programmable output-sample divider and the interpolation rate.
- Buffers one upstream sample behind a valid/ready handshake and drives it onto the interpolator input.
- Owns rate reconfiguration: holds the interpolator disabled for a flush window so the integrators restart clean at the new rate.

---
 rtl/cic_sched_pkg.sv | 17 +
 rtl/cic_strobe_divider.sv | 52 +++++
 rtl/cic_interp_scheduler.sv | 168 ++++++++++++++++
 tb/tb_cic_interp_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_sched_pkg.sv
// Shared definitions for the CIC interpolator scheduler: FSM encoding,
// the default interpolation rate and the zero-to-one rate clamp.
package cic_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [7:0] CIC_RATE_DEFAULT = 8'd8;

    function automatic logic [7:0] clamp_rate(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/cic_strobe_divider.sv
// Output-sample divider and interpolation phase counter; emits registered
// stb_out on every divider tick and stb_in on ticks that land on phase 0.
module cic_strobe_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div_last,
    input  logic [7:0]       rate,
    output logic             load,
    output logic             stb_out,
    output logic             stb_in
);

    logic [DIV_W-1:0] div_cnt_r;
    logic [7:0]       phase_r;
    logic             stb_out_r;
    logic             stb_in_r;
    logic             tick_s;
    logic             phase_wrap_s;

    // Tick decode; load marks the tick that will raise the input strobe
    always_comb begin
        tick_s       = ~clear & (div_cnt_r == div_last);
        phase_wrap_s = (phase_r >= (rate - 8'd1));
        load         = tick_s & (phase_r == 8'd0);
    end

    // Counters restart from zero whenever the scheduler is not running
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt_r <= {DIV_W{1'b0}};
            phase_r   <= 8'd0;
            stb_out_r <= 1'b0;
            stb_in_r  <= 1'b0;
        end else begin
            stb_out_r <= tick_s;
            stb_in_r  <= load;
            if (tick_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                phase_r   <= phase_wrap_s ? 8'd0 : phase_r + 8'd1;
            end else begin
                div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stb_out = stb_out_r;
    assign stb_in  = stb_in_r;

endmodule

// File: rtl/cic_interp_scheduler.sv
// Sequencing controller for the 4-stage CIC interpolator: run/flush FSM,
// rate reconfiguration, one-entry sample holding register and underrun count.
module cic_interp_scheduler
    import cic_sched_pkg::*;
#(
    parameter int         WIDTH        = 16,
    parameter int         DIV_W        = 16,
    parameter int         FLUSH_CYCLES = 4,
    parameter logic [7:0] RATE_DEFAULT = CIC_RATE_DEFAULT,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] out_div,
    input  logic [7:0]       cfg_rate,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             cic_enable,
    output logic [7:0]       cic_rate,
    output logic [WIDTH-1:0] cic_data_in,
    output logic             cic_stb_in,
    output logic             cic_stb_out,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic             busy
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t           state_r;
    logic [FC_W-1:0]  flush_cnt_r;
    logic [DIV_W-1:0] div_last_r;
    logic             cic_enable_r;
    logic             busy_r;
    logic [7:0]       cic_rate_r;
    logic             full_r;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] underrun_r;
    logic             cfg_ready_s;
    logic             accept_s;
    logic             s_ready_s;
    logic             xfer_s;
    logic             div_clear_s;
    logic             load_s;

    // Handshake decode; any departure from RUN also drops a pending strobe
    always_comb begin
        cfg_ready_s = (state_r == ST_IDLE) || (state_r == ST_RUN);
        accept_s    = cfg_valid & cfg_ready_s;
        s_ready_s   = (state_r == ST_RUN) & ~full_r;
        xfer_s      = s_valid & s_ready_s;
        div_clear_s = (state_r != ST_RUN) | ~enable | accept_s;
    end

    // Run/flush sequencing and rate register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            flush_cnt_r  <= {FC_W{1'b0}};
            div_last_r   <= {DIV_W{1'b0}};
            cic_enable_r <= 1'b0;
            busy_r       <= 1'b0;
            cic_rate_r   <= RATE_DEFAULT;
        end else begin
            if (accept_s) begin
                cic_rate_r <= clamp_rate(cfg_rate);
            end
            if (!enable) begin
                state_r      <= ST_IDLE;
                flush_cnt_r  <= {FC_W{1'b0}};
                cic_enable_r <= 1'b0;
                busy_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!accept_s) begin
                            state_r     <= ST_FLUSH;
                            flush_cnt_r <= {FC_W{1'b0}};
                            busy_r      <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt_r == {FC_W{1'b0}}) begin
                            div_last_r <= (out_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}}
                                        : out_div - {{(DIV_W-1){1'b0}}, 1'b1};
                        end
                        if (flush_cnt_r == FC_W'(FLUSH_CYCLES - 1)) begin
                            state_r      <= ST_RUN;
                            flush_cnt_r  <= {FC_W{1'b0}};
                            busy_r       <= 1'b0;
                            cic_enable_r <= 1'b1;
                        end else begin
                            flush_cnt_r <= flush_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_RUN: begin
                        if (accept_s) begin
                            state_r      <= ST_FLUSH;
                            flush_cnt_r  <= {FC_W{1'b0}};
                            busy_r       <= 1'b1;
                            cic_enable_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        flush_cnt_r  <= {FC_W{1'b0}};
                        busy_r       <= 1'b0;
                        cic_enable_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register; a sample taken on a load cycle waits for the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r     <= 1'b0;
            hold_r     <= {WIDTH{1'b0}};
            data_r     <= {WIDTH{1'b0}};
            underrun_r <= {CNT_W{1'b0}};
        end else if (!enable) begin
            full_r <= 1'b0;
        end else begin
            if (load_s) begin
                if (full_r) begin
                    data_r <= hold_r;
                    full_r <= 1'b0;
                end else begin
                    data_r <= {WIDTH{1'b0}};
                    if (~&underrun_r) begin
                        underrun_r <= underrun_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            if (xfer_s) begin
                hold_r <= s_data;
                full_r <= 1'b1;
            end
        end
    end

    cic_strobe_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (div_clear_s),
        .div_last (div_last_r),
        .rate     (cic_rate_r),
        .load     (load_s),
        .stb_out  (cic_stb_out),
        .stb_in   (cic_stb_in)
    );

    assign cfg_ready    = cfg_ready_s;
    assign s_ready      = s_ready_s;
    assign cic_enable   = cic_enable_r;
    assign busy         = busy_r;
    assign cic_rate     = cic_rate_r;
    assign cic_data_in  = data_r;
    assign underrun_cnt = underrun_r;

endmodule

// File: tb/tb_cic_interp_scheduler.sv
// Directed bench for cic_interp_scheduler with a cycle-level reference model
// and a sample scoreboard popped on every expected input strobe.
module tb_cic_interp_scheduler;

    logic        clk = 1'b0;
    logic        rst, enable, cfg_valid, s_valid;
    logic [15:0] out_div, s_data;
    logic [7:0]  cfg_rate;
    logic        cfg_ready, s_ready, cic_enable, cic_stb_in, cic_stb_out, busy;
    logic [7:0]  cic_rate;
    logic [15:0] cic_data_in, underrun_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state: 0 IDLE, 1 FLUSH, 2 RUN
    int          m_state = 0, m_fc = 0, m_D = 1, m_rate = 8, m_k = 0, m_nt = 0;
    logic        e_sout = 1'b0, e_sin = 1'b0;
    logic [15:0] e_data = 16'd0;
    int          e_under = 0;
    logic [15:0] sb[$];
    int          n_sout, n_sin;

    cic_interp_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .out_div      (out_div),
        .cfg_rate     (cfg_rate),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .cic_enable   (cic_enable),
        .cic_rate     (cic_rate),
        .cic_data_in  (cic_data_in),
        .cic_stb_in   (cic_stb_in),
        .cic_stb_out  (cic_stb_out),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance the model with the inputs present at the coming edge, then compare
    task automatic step();
        bit acc, tick, sacc;
        if (rst) begin
            m_state = 0; m_fc = 0; m_rate = 8; e_sout = 1'b0; e_sin = 1'b0;
            e_data = 16'd0; e_under = 0; sb.delete();
        end else begin
            acc  = cfg_valid && (m_state == 0 || m_state == 2);
            tick = (m_state == 2) && enable && !acc && (((m_k + 1) % m_D) == 0);
            e_sout = tick;
            e_sin  = tick && ((m_nt % m_rate) == 0);
            sacc = s_valid && (m_state == 2) && (sb.size() == 0);
            if (!enable) begin
                sb.delete();
            end else begin
                if (e_sin) begin
                    if (sb.size() > 0) e_data = sb.pop_front();
                    else begin
                        e_data = 16'd0;
                        if (e_under < 65535) e_under++;
                    end
                end
                if (sacc) sb.push_back(s_data);
            end
            if (acc) m_rate = (cfg_rate == 8'd0) ? 1 : int'(cfg_rate);
            if (!enable) m_state = 0;
            else begin
                case (m_state)
                    0: if (!acc) begin m_state = 1; m_fc = 0; end
                    1: begin
                        if (m_fc == 0) m_D = (out_div == 16'd0) ? 1 : int'(out_div);
                        if (m_fc == 3) begin m_state = 2; m_k = 0; m_nt = 0; end
                        else m_fc++;
                    end
                    default: begin
                        if (acc) begin m_state = 1; m_fc = 0; end
                        else begin m_k++; if (tick) m_nt++; end
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        chk("cic_enable", 32'(cic_enable), 32'(m_state == 2));
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_state != 1));
        chk("s_ready", 32'(s_ready), 32'((m_state == 2) && (sb.size() == 0)));
        chk("cic_rate", 32'(cic_rate), 32'(m_rate));
        chk("cic_stb_out", 32'(cic_stb_out), 32'(e_sout));
        chk("cic_stb_in", 32'(cic_stb_in), 32'(e_sin));
        chk("cic_data_in", 32'(cic_data_in), 32'(e_data));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(e_under));
        if (cic_stb_out) n_sout++;
        if (cic_stb_in) n_sin++;
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) s_data = 16'($urandom);
            step();
        end
    endtask

    task automatic wait_sin(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = cic_stb_in;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=cic_stb_in", tag);
        end
    endtask

    task automatic cfg(input logic [7:0] r);
        cfg_valid = 1'b1; cfg_rate = r;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_rate = 8'd0;
        s_valid = 1'b0; s_data = 16'd0; out_div = 16'd3;
        n_sout = 0; n_sin = 0;
        run(2, 1'b0);
        chk("reset_rate", 32'(cic_rate), 32'd8);
        chk("reset_data", 32'(cic_data_in), 32'd0);
        rst = 1'b0;

        // rate 4, divider 3, continuous upstream samples
        cfg(8'd4);
        enable = 1'b1; s_valid = 1'b1;
        n_sout = 0; n_sin = 0;
        run(4, 1'b1);
        chk("flush_busy", 32'(busy), 32'd1);
        run(1, 1'b1);
        chk("run_enable", 32'(cic_enable), 32'd1);
        run(36, 1'b1);
        chk("stb_out_count", 32'(n_sout), 32'd12);
        chk("stb_in_count", 32'(n_sin), 32'd3);
        chk("no_underrun", 32'(underrun_cnt), 32'd0);

        // starve the holding register, then deliver one known sample
        s_valid = 1'b0;
        run(40, 1'b0);
        wait_sin("sync_before_sample", 20);
        s_valid = 1'b1; s_data = 16'h1234;
        step();
        s_valid = 1'b0;
        wait_sin("sample_strobe", 20);
        chk("sample_1234", 32'(cic_data_in), 32'h1234);

        // rate change mid-period restarts through FLUSH
        s_valid = 1'b1;
        wait_sin("sync_before_cfg", 20);
        step();
        cfg(8'd8);
        chk("cfg_busy", 32'(busy), 32'd1);
        chk("cfg_ready_low", 32'(cfg_ready), 32'd0);
        chk("cfg_rate8", 32'(cic_rate), 32'd8);
        run(80, 1'b1);

        // zero rate and zero divider clamp to one
        enable = 1'b0; step();
        out_div = 16'd0;
        cfg(8'd0);
        enable = 1'b1;
        run(20, 1'b1);
        chk("d1_stb_out", 32'(cic_stb_out), 32'd1);
        chk("d1_stb_in", 32'(cic_stb_in), 32'd1);

        // drop enable while a sample is held, then restart
        enable = 1'b0; step();
        cfg(8'd4);
        out_div = 16'd5; enable = 1'b1;
        run(12, 1'b1);
        for (int i = 0; i < 20 && s_ready; i++) step();
        chk("held_full", 32'(s_ready), 32'd0);
        enable = 1'b0; step();
        chk("drop_stb_out", 32'(cic_stb_out), 32'd0);
        chk("drop_s_ready", 32'(s_ready), 32'd0);
        enable = 1'b1;
        run(40, 1'b1);

        // reset mid-run at rate 8
        cfg(8'd8);
        run(30, 1'b1);
        rst = 1'b1; step();
        chk("rst_under", 32'(underrun_cnt), 32'd0);
        chk("rst_enable", 32'(cic_enable), 32'd0);
        rst = 1'b0; enable = 1'b0;
        run(3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
